// File: rtl/decypher.sv
// decypher: receive-side one-time-pad decryptor.
// Regenerates the keystream from a shared 8-bit seed using an 8-bit LFSR and
// XORs it with each accepted ciphertext word. The keystream runs continuously
// across words, so it stays in lockstep with the sender after a single load.
//
// Ports:
//   clk        in          rising-edge clock
//   reset      in          asynchronous active-low reset
//   seed       in  [7:0]   keystream seed, sampled on load
//   load       in          (re)start keystream from seed
//   in_valid   in          ciphertext word valid
//   in_ready   out         ciphertext accepted this cycle
//   ciphertext in  [MSG_W] encrypted word
//   out_valid  out         plaintext word valid
//   out_ready  in          consumer takes plaintext this cycle
//   plaintext  out [MSG_W] decrypted word
//   word_count out [15:0]  words delivered since last load (wraps)
module decypher #(
  parameter int unsigned MSG_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       seed,
  input  logic             load,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] ciphertext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MSG_W-1:0] plaintext,
  output logic [15:0]      word_count
);

  localparam int unsigned B  = MSG_W / 8;
  localparam int unsigned CW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [1:0] {IDLE, GEN, READY, OUT} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_lfsr;
  logic [MSG_W-1:0] r_pad;
  logic [CW-1:0]    r_gen_cnt;
  logic [MSG_W-1:0] r_plaintext;
  logic             r_out_valid;
  logic [15:0]      r_word_count;

  logic [7:0]       w_lfsr_next;
  logic [MSG_W-1:0] w_pad_shift;
  logic             w_gen_last;

  assign w_lfsr_next = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_gen_last  = (r_gen_cnt == CW'(B - 1));

  // Newest keystream byte enters at the LSB so the first step ends up in the MSB byte.
  generate
    if (MSG_W == 8) begin : g_pad_one
      assign w_pad_shift = w_lfsr_next;
    end else begin : g_pad_many
      assign w_pad_shift = {r_pad[MSG_W-9:0], w_lfsr_next};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (load) begin
      w_next_state = GEN;
    end else begin
      case (r_state)
        IDLE:    w_next_state = IDLE;
        GEN:     if (w_gen_last) w_next_state = READY;
        READY:   if (in_valid)   w_next_state = OUT;
        OUT:     if (out_ready)  w_next_state = GEN;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // load takes priority over any handshake in progress and drops pending plaintext.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lfsr       <= '0;
      r_pad        <= '0;
      r_gen_cnt    <= '0;
      r_plaintext  <= '0;
      r_out_valid  <= 1'b0;
      r_word_count <= '0;
    end else if (load) begin
      r_lfsr       <= (seed == 8'h00) ? 8'h01 : seed;
      r_pad        <= '0;
      r_gen_cnt    <= '0;
      r_out_valid  <= 1'b0;
      r_word_count <= '0;
    end else begin
      case (r_state)
        GEN: begin
          r_lfsr    <= w_lfsr_next;
          r_pad     <= w_pad_shift;
          r_gen_cnt <= w_gen_last ? '0 : r_gen_cnt + 1'b1;
        end
        READY: begin
          if (in_valid) begin
            r_plaintext <= ciphertext ^ r_pad;
            r_out_valid <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid  <= 1'b0;
            r_word_count <= r_word_count + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (r_state == READY) & ~load;
  assign out_valid  = r_out_valid;
  assign plaintext  = r_plaintext;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_decypher.sv
module tb_decypher;

  logic        clk;
  logic        reset;
  logic [7:0]  seed;
  logic        load;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ciphertext;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] plaintext;
  logic [15:0] word_count;

  int unsigned n_cmp;
  int unsigned n_bad;

  // Reference model state: keystream byte generator and delivered-word counter.
  logic [7:0]  m_lfsr;
  logic [15:0] m_wc;

  decypher #(.MSG_W(64)) dut (
    .clk(clk), .reset(reset), .seed(seed), .load(load),
    .in_valid(in_valid), .in_ready(in_ready), .ciphertext(ciphertext),
    .out_valid(out_valid), .out_ready(out_ready), .plaintext(plaintext),
    .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ks_step(input logic [7:0] s);
    logic fb;
    fb = s[7] ^ s[5] ^ s[4] ^ s[3];
    return {s[6:0], fb};
  endfunction

  // Next 64-bit pad: eight keystream bytes, first byte in the MSB position.
  task automatic model_pad(output logic [63:0] p);
    p = '0;
    for (int i = 0; i < 8; i++) begin
      m_lfsr = ks_step(m_lfsr);
      p[63 - 8*i -: 8] = m_lfsr;
    end
  endtask

  task automatic do_load(input logic [7:0] s);
    load = 1'b1;
    seed = s;
    @(negedge clk);
    load   = 1'b0;
    m_lfsr = (s == 8'h00) ? 8'h01 : s;
    m_wc   = '0;
  endtask

  // Sends one word, checks the plaintext, holds out_ready low a random time, then releases.
  task automatic run_word(input logic [63:0] ct, input logic [63:0] exp_pt,
                          input string tag, output logic [63:0] got_pt);
    bit got;
    int unsigned hold;
    in_valid   = 1'b1;
    ciphertext = ct;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) got = 1;
    end
    in_valid = 1'b0;
    got_pt = plaintext;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s_timeout: out_valid=%b required 1 within 40 cycles", tag, out_valid);
      return;
    end
    if (plaintext !== exp_pt) begin
      n_bad++;
      $display("FAIL %s_pt: got %h required %h", tag, plaintext, exp_pt);
    end
    hold = $urandom_range(0, 3);
    for (int i = 0; i < int'(hold); i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || plaintext !== exp_pt || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_hold: ov=%b pt=%h ir=%b required ov=1 pt=%h ir=0",
                 tag, out_valid, plaintext, in_ready, exp_pt);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_wc = m_wc + 16'd1;
    n_cmp++;
    if (out_valid !== 1'b0 || word_count !== m_wc) begin
      n_bad++;
      $display("FAIL %s_release: ov=%b wc=%0d required ov=0 wc=%0d", tag, out_valid, word_count, m_wc);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || plaintext !== 64'h0 || word_count !== 16'h0) begin
      n_bad++;
      $display("FAIL reset_state: ir=%b ov=%b pt=%h wc=%h required 0 0 0 0",
               in_ready, out_valid, plaintext, word_count);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_no_load: ir=%b ov=%b required 0 0", in_ready, out_valid);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_first_word;
    logic exp_ov, exp_ir;
    do_load(8'h33);
    in_valid = 1'b1;
    ciphertext = '0;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL gen_in_ready_k0: got %b required 0", in_ready);
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      exp_ov = (k == 9);
      exp_ir = (k == 8);
      n_cmp++;
      if (out_valid !== exp_ov || in_ready !== exp_ir) begin
        n_bad++;
        $display("FAIL latency_k%0d: ov=%b ir=%b required ov=%b ir=%b", k, out_valid, in_ready, exp_ov, exp_ir);
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (plaintext !== 64'h66CD9A356AD4A851) begin
      n_bad++;
      $display("FAIL first_pad: got %h required 66cd9a356ad4a851", plaintext);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || word_count !== 16'd1) begin
      n_bad++;
      $display("FAIL first_release: ov=%b wc=%0d required 0 1", out_valid, word_count);
    end
  endtask

  task automatic test_known_ct;
    logic [63:0] pt;
    do_load(8'h33);
    run_word(64'h66CD9A356AD4A851, 64'h0, "known_ct", pt);
    n_cmp++;
    if (word_count !== 16'd1) begin
      n_bad++;
      $display("FAIL known_ct_wc: got %0d required 1", word_count);
    end
  endtask

  task automatic test_loopback;
    logic [63:0] pad, msg, pt;
    do_load(8'h33);
    for (int w = 0; w < 4; w++) begin
      msg = {$urandom, $urandom};
      model_pad(pad);
      run_word(msg ^ pad, msg, "loopback", pt);
    end
    n_cmp++;
    if (word_count !== 16'd4) begin
      n_bad++;
      $display("FAIL loopback_wc: got %0d required 4", word_count);
    end
  endtask

  task automatic test_zero_seed;
    logic [63:0] pad, pt;
    do_load(8'h00);
    model_pad(pad);
    run_word(64'h0, pad, "zero_seed", pt);
    n_cmp++;
    if (pt[63:56] !== 8'h02) begin
      n_bad++;
      $display("FAIL zero_seed_msb: got %h required 02", pt[63:56]);
    end
  endtask

  task automatic test_hold_then_load;
    logic [63:0] pad, msg, pt, held;
    logic [7:0]  s;
    bit got;
    s = 8'($urandom_range(1, 255));
    do_load(s);
    model_pad(pad);
    msg = {$urandom, $urandom};
    run_word(msg ^ pad, msg, "hold_w0", pt);
    model_pad(pad);
    msg = {$urandom, $urandom};
    in_valid = 1'b1;
    ciphertext = msg ^ pad;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) got = 1;
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL hold_timeout: out_valid=%b required 1 within 40 cycles", out_valid);
    end
    held = plaintext;
    // in_valid stays high: a second word must not be taken while one is pending.
    ciphertext = ~ciphertext;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || plaintext !== msg || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_stable_%0d: ov=%b pt=%h ir=%b required ov=1 pt=%h ir=0",
                 i, out_valid, plaintext, in_ready, msg);
      end
    end
    in_valid = 1'b0;
    s = 8'($urandom_range(1, 255));
    out_ready = 1'b1;
    do_load(s);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || word_count !== 16'd0 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL load_wins: ov=%b wc=%0d ir=%b required 0 0 0", out_valid, word_count, in_ready);
    end
    model_pad(pad);
    msg = {$urandom, $urandom};
    run_word(msg ^ pad, msg, "after_reload", pt);
  endtask

  task automatic test_reset_mid_gen;
    logic [63:0] pad, msg, pt;
    bit seen;
    do_load(8'h5A);
    model_pad(pad);
    run_word(64'h0123456789ABCDEF ^ pad, 64'h0123456789ABCDEF, "pre_reset", pt);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || word_count !== 16'd0 || plaintext !== 64'h0) begin
      n_bad++;
      $display("FAIL reset_mid_gen: ir=%b ov=%b wc=%0d pt=%h required 0 0 0 0",
               in_ready, out_valid, word_count, plaintext);
    end
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b0) seen = 1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL no_output_after_reset: activity seen=%b required 0", seen);
    end
    do_load(8'hC3);
    model_pad(pad);
    msg = {$urandom, $urandom};
    run_word(msg ^ pad, msg, "post_reset", pt);
  endtask

  task automatic test_back_to_back;
    logic [63:0] pad, msg, pt;
    for (int r = 0; r < 3; r++) begin
      do_load(8'($urandom));
      for (int w = 0; w < 5; w++) begin
        model_pad(pad);
        msg = {$urandom, $urandom};
        run_word(msg ^ pad, msg, "b2b", pt);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    seed = '0; load = 1'b0; in_valid = 1'b0; ciphertext = '0; out_ready = 1'b0;
    m_lfsr = '0; m_wc = '0;
    test_reset();
    test_first_word();
    test_known_ct();
    test_loopback();
    test_zero_seed();
    test_hold_then_load();
    test_reset_mid_gen();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
